// File: rtl/hyperbus_wb_bridge.sv
// hyperbus_wb_bridge: Wishbone slave serialising wide accesses into HyperBus word requests
module hyperbus_wb_bridge #(
   parameter int WB_DATA_WIDTH   = 32,
   parameter int WB_ADDR_WIDTH   = 32,
   parameter int HBUS_DATA_WIDTH = 16,
   parameter int HBUS_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                         wb_clk,
   input  logic                         wb_rst_n,
   input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
   input  logic [WB_DATA_WIDTH-1:0]     wb_dat_i,
   input  logic [WB_DATA_WIDTH/8-1:0]   wb_sel_i,
   input  logic                         wb_we_i,
   input  logic                         wb_cyc_i,
   input  logic                         wb_stb_i,
   input  logic [2:0]                   wb_cti_i,
   input  logic [1:0]                   wb_bte_i,
   output logic [WB_DATA_WIDTH-1:0]     wb_dat_o,
   output logic                         wb_ack_o,
   output logic                         wb_err_o,
   output logic                         wb_rty_o,
   output logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_o,
   output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
   output logic [HBUS_DATA_WIDTH/8-1:0] hbus_sel_o,
   output logic                         hbus_wrq,
   output logic                         hbus_rrq,
   input  logic                         hbus_ready,
   input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
   input  logic                         hbus_valid,
   input  logic                         hbus_busy
);
   localparam int R  = WB_DATA_WIDTH / HBUS_DATA_WIDTH;
   localparam int BW = HBUS_DATA_WIDTH / 8;
   localparam int SB = $clog2(BW);
   localparam int KW = $clog2(R) + 1;
   typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, ACK} state_t;
   state_t state, state_nx;
   logic [HBUS_ADDR_WIDTH-1:0] base;
   logic [WB_DATA_WIDTH-1:0] dat;
   logic [WB_DATA_WIDTH/8-1:0] sel;
   logic [KW-1:0] k, k_nx, cur, nxt;
   logic [31:0] cnt;
   logic [HBUS_DATA_WIDTH-1:0] wdat;
   logic [BW-1:0] wsel;
   logic abort, err_f, err_nx, hs, pend, tmo, abrt, start;
   logic unused;
   assign unused = ^{wb_cti_i, wb_bte_i};
   assign start = wb_cyc_i & wb_stb_i & ~hbus_busy;
   assign abrt = abort | ~wb_cyc_i;
   assign hs = ((hbus_wrq | hbus_rrq) & hbus_ready) | (state == READ_WAIT & hbus_valid);
   assign pend = hbus_wrq | hbus_rrq | state == READ_WAIT;
   assign tmo = TIMEOUT_CYCLES != 0 && pend && !hs && cnt == 32'(TIMEOUT_CYCLES - 1);
   // find the current and following write words that have any byte selected
   always_comb begin
      cur = KW'(R);
      nxt = KW'(R);
      wdat = '0;
      wsel = '0;
      for (int i = R - 1; i >= 0; i--)
         if (i >= int'(k) && sel[i*BW +: BW] != '0) begin
            cur = KW'(i);
            wdat = dat[i*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
            wsel = sel[i*BW +: BW];
         end
      for (int i = R - 1; i >= 0; i--)
         if (i > int'(cur) && sel[i*BW +: BW] != '0) nxt = KW'(i);
   end
   // HBUS request and WB termination outputs decoded from state
   always_comb begin
      hbus_wrq = state == WRITE && cur != KW'(R);
      hbus_rrq = state == READ_REQ;
      hbus_adr_o = hbus_wrq ? base + HBUS_ADDR_WIDTH'(cur) : hbus_rrq ? base + HBUS_ADDR_WIDTH'(k) : '0;
      hbus_dat_o = hbus_wrq ? wdat : '0;
      hbus_sel_o = hbus_wrq ? wsel : hbus_rrq ? '1 : '0;
      wb_ack_o = state == ACK && !err_f;
      wb_err_o = state == ACK && err_f;
      wb_rty_o = 1'b0;
   end
   // next-state logic: word sequencing, abort drain and timeout
   always_comb begin
      state_nx = state;
      k_nx = k;
      err_nx = err_f;
      case (state)
         IDLE: if (start) begin
            state_nx = wb_we_i ? WRITE : READ_REQ;
            k_nx = '0;
            err_nx = 1'b0;
         end
         WRITE: if (tmo) begin
            state_nx = abrt ? IDLE : ACK;
            err_nx = 1'b1;
         end else if (cur == KW'(R)) state_nx = abrt ? IDLE : ACK;
         else if (hs) begin
            state_nx = abrt ? IDLE : nxt == KW'(R) ? ACK : WRITE;
            k_nx = nxt;
         end
         READ_REQ: if (tmo) begin
            state_nx = abrt ? IDLE : ACK;
            err_nx = 1'b1;
         end else if (hs) state_nx = READ_WAIT;
         READ_WAIT: if (tmo) begin
            state_nx = abrt ? IDLE : ACK;
            err_nx = 1'b1;
         end else if (hs) begin
            state_nx = abrt ? IDLE : k == KW'(R - 1) ? ACK : READ_REQ;
            k_nx = k + KW'(1);
         end
         default: state_nx = IDLE;
      endcase
   end
   // state, captured request, timeout counter and read data registers
   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         k <= '0;
         cnt <= '0;
         abort <= 1'b0;
         err_f <= 1'b0;
         base <= '0;
         dat <= '0;
         sel <= '0;
         wb_dat_o <= '0;
      end else begin
         state <= state_nx;
         k <= k_nx;
         err_f <= err_nx;
         cnt <= (state == IDLE || hs || !pend) ? '0 : cnt + 32'd1;
         abort <= (state == IDLE || state == ACK) ? 1'b0 : abrt;
         if (state == IDLE && start) begin
            base <= HBUS_ADDR_WIDTH'((wb_adr_i >> SB) & ~WB_ADDR_WIDTH'(R - 1));
            dat <= wb_dat_i;
            sel <= wb_sel_i;
         end
         if (state == READ_WAIT && hbus_valid && !abrt)
            for (int i = 0; i < R; i++)
               if (i == int'(k)) wb_dat_o[i*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH] <= hbus_dat_i;
      end
   end
endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// tb_hyperbus_wb_bridge: scoreboard bench for the Wishbone to HyperBus bridge
module tb_hyperbus_wb_bridge;
   logic clk = 0, rst_n = 0;
   logic [31:0] wb_adr = 0, wb_dat = 0;
   logic [3:0] wb_sel = 0;
   logic wb_we = 0, wb_cyc = 0, wb_stb = 0;
   logic [2:0] wb_cti = 0;
   logic [1:0] wb_bte = 0;
   logic [31:0] wb_dat_o;
   logic wb_ack_o, wb_err_o, wb_rty_o;
   logic [31:0] hbus_adr_o;
   logic [15:0] hbus_dat_o;
   logic [1:0] hbus_sel_o;
   logic hbus_wrq, hbus_rrq;
   logic hbus_ready = 1;
   logic [15:0] hbus_dat_i = 0;
   logic hbus_valid = 0;
   logic hbus_busy = 0;
   typedef struct {int kind; logic [31:0] adr; logic [31:0] dat; logic [1:0] sel; int gap; bit chk;} ev_t;
   ev_t exp_q[$];
   logic [15:0] rdq[$];
   int checks = 0, errors = 0, ncyc = 0, t_start = 0, last_ev = 0, stall = 0;

   hyperbus_wb_bridge #(.TIMEOUT_CYCLES(16)) dut (
      .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
      .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
      .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_sel_o(hbus_sel_o),
      .hbus_wrq(hbus_wrq), .hbus_rrq(hbus_rrq), .hbus_ready(hbus_ready),
      .hbus_dat_i(hbus_dat_i), .hbus_valid(hbus_valid), .hbus_busy(hbus_busy));

   always #5 clk = ~clk;

   task automatic push(input int kind, input logic [31:0] adr, dat, input logic [1:0] sel, input int gap, input bit chk);
      exp_q.push_back('{kind, adr, dat, sel, gap, chk});
   endtask

   task automatic got(input int kind, input logic [31:0] adr, dat, input logic [1:0] sel);
      int gap = ncyc - ((t_start > last_ev) ? t_start : last_ev);
      ev_t e;
      last_ev = ncyc;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d adr=%h dat=%h sel=%b required none", kind, adr, dat, sel);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.adr != adr || e.sel != sel || (e.chk && e.dat != dat) || (e.gap >= 0 && e.gap != gap)) begin
            errors++;
            $display("FAIL event got kind=%0d adr=%h dat=%h sel=%b gap=%0d required kind=%0d adr=%h dat=%h sel=%b gap=%0d",
                     kind, adr, dat, sel, gap, e.kind, e.adr, e.dat, e.sel, e.gap);
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, act, exp);
      end
   endtask

   // monitor: every handshake or termination is matched against the scoreboard
   always @(negedge clk) begin
      ncyc++;
      if (rst_n) begin
         if (hbus_wrq && !hbus_ready) stall++;
         if (hbus_wrq && hbus_ready) got(0, hbus_adr_o, {16'h0, hbus_dat_o}, hbus_sel_o);
         if (hbus_rrq && hbus_ready) got(1, hbus_adr_o, 32'h0, hbus_sel_o);
         if (wb_ack_o) got(2, 32'h0, wb_dat_o, 2'b00);
         if (wb_err_o) got(3, 32'h0, wb_dat_o, 2'b00);
      end
   end

   // HyperBus read responder: data returns 3 cycles after each accepted read request
   always begin
      @(negedge clk);
      if (hbus_rrq && hbus_ready) begin
         @(posedge clk);
         repeat (2) @(posedge clk);
         #1 hbus_valid = 1;
         hbus_dat_i = rdq.size() != 0 ? rdq.pop_front() : 16'h0;
         @(posedge clk);
         #1 hbus_valid = 0;
      end
   end

   task automatic xfer(input logic we, input logic [31:0] adr, dat, input logic [3:0] sel, input logic [2:0] cti, input bit keep);
      bit done = 0;
      @(posedge clk);
      #1;
      wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_cti = cti;
      t_start = ncyc;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = wb_ack_o || wb_err_o;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL term_timeout adr=%h got no ack/err required termination", adr);
      end
      if (!keep) begin
         @(posedge clk);
         #1 wb_cyc = 0; wb_stb = 0;
      end
   endtask

   initial begin
      int s0;
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wrq", {31'h0, hbus_wrq}, 0);
      chk("rst_rrq", {31'h0, hbus_rrq}, 0);
      chk("rst_ack", {31'h0, wb_ack_o}, 0);
      chk("rst_err", {31'h0, wb_err_o}, 0);
      chk("rst_rty", {31'h0, wb_rty_o}, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_adr", hbus_adr_o, 0);
      rst_n = 1;
      // full-word and masked writes
      push(0, 32'h80, 32'hBEEF, 2'b11, 2, 0); push(0, 32'h81, 32'hDEAD, 2'b11, 1, 0); push(2, 0, 0, 0, 1, 0);
      xfer(1, 32'h100, 32'hDEADBEEF, 4'b1111, 3'b000, 0);
      push(0, 32'h81, 32'hDEAD, 2'b11, 2, 0); push(2, 0, 0, 0, 1, 0);
      xfer(1, 32'h100, 32'hDEADBEEF, 4'b1100, 3'b000, 0);
      push(0, 32'h80, 32'hBEEF, 2'b10, 2, 0); push(2, 0, 0, 0, 1, 0);
      xfer(1, 32'h100, 32'hDEADBEEF, 4'b0010, 3'b000, 0);
      push(2, 0, 0, 0, 3, 0);
      xfer(1, 32'h100, 32'hDEADBEEF, 4'b0000, 3'b000, 0);
      // classic read
      rdq.push_back(16'h3412); rdq.push_back(16'h7856);
      push(1, 32'h100, 0, 2'b11, 2, 0); push(1, 32'h101, 0, 2'b11, 4, 0); push(2, 0, 32'h78563412, 0, 4, 1);
      xfer(0, 32'h200, 0, 4'b1111, 3'b000, 0);
      // incrementing burst read
      for (int j = 0; j < 4; j++) begin
         rdq.push_back(16'(16'h1100 + j)); rdq.push_back(16'(16'h2200 + j));
         push(1, 32'(2 * j), 0, 2'b11, 2, 0); push(1, 32'(2 * j + 1), 0, 2'b11, 4, 0);
         push(2, 0, {16'(16'h2200 + j), 16'(16'h1100 + j)}, 0, 4, 1);
         xfer(0, 32'(4 * j), 0, 4'b1111, j == 3 ? 3'b111 : 3'b010, j != 3);
      end
      repeat (10) @(posedge clk);
      // timeout on a stalled write, then a normal write
      #1 hbus_ready = 0;
      s0 = stall;
      push(3, 0, 0, 0, 18, 0);
      xfer(1, 32'h300, 32'h12345678, 4'b1111, 3'b000, 0);
      chk("timeout_wrq_cycles", 32'(stall - s0), 16);
      #1 hbus_ready = 1;
      push(0, 32'h180, 32'h5678, 2'b11, 2, 0); push(0, 32'h181, 32'h1234, 2'b11, 1, 0); push(2, 0, 0, 0, 1, 0);
      xfer(1, 32'h300, 32'h12345678, 4'b1111, 3'b000, 0);
      // reset while waiting for read data
      rdq.push_back(16'hAAAA);
      push(1, 32'h100, 0, 2'b11, 2, 0);
      @(posedge clk);
      #1 wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h200; wb_sel = 4'hF; wb_cti = 0;
      t_start = ncyc;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = hbus_rrq && hbus_ready;
      end
      chk("reset_rrq_seen", {31'h0, seen}, 1);
      @(posedge clk);
      #1 rst_n = 0; wb_cyc = 0; wb_stb = 0;
      @(posedge clk);
      #1;
      chk("midrst_rrq", {31'h0, hbus_rrq}, 0);
      chk("midrst_wrq", {31'h0, hbus_wrq}, 0);
      chk("midrst_ack", {31'h0, wb_ack_o}, 0);
      chk("midrst_err", {31'h0, wb_err_o}, 0);
      chk("midrst_dat", wb_dat_o, 0);
      @(posedge clk);
      #1 rst_n = 1;
      repeat (6) @(posedge clk);
      // cycle abort mid-write: in-flight word completes, no ack
      #1 hbus_ready = 0;
      wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h400; wb_dat = 32'hCAFEF00D; wb_sel = 4'hF;
      t_start = ncyc;
      push(0, 32'h200, 32'hF00D, 2'b11, -1, 0);
      repeat (3) @(posedge clk);
      #1 wb_cyc = 0; wb_stb = 0;
      @(posedge clk);
      #1 hbus_ready = 1;
      repeat (10) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish required completion");
      $fatal(1);
   end
endmodule
